data_ram: RTL and testbench



---
 rtl/data_ram_pkg.sv | 22 ++
 rtl/data_ram_if.sv | 15 +
 rtl/data_ram_lane.sv | 24 ++
 rtl/data_ram.sv | 131 +++++++++++++
 tb/tb_data_ram.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/data_ram_pkg.sv
// Shared constants, state encoding and lane helper for the data-side memory.
package data_ram_pkg;

   localparam int unsigned RegBus         = 32;
   localparam int unsigned ByteWidth      = 8;
   localparam int unsigned DataMemNumLog2 = 10;
   localparam int unsigned NumLanes       = RegBus / ByteWidth;

   localparam logic ChipEnable  = 1'b1;
   localparam logic WriteEnable = 1'b1;

   typedef enum logic {
      DRAM_INIT = 1'b0,
      DRAM_RUN  = 1'b1
   } dram_state_e;

   function automatic logic [ByteWidth-1:0] lane_byte(input logic [RegBus-1:0] word,
                                                      input int unsigned       k);
      return word[k*ByteWidth +: ByteWidth];
   endfunction

endpackage

// File: rtl/data_ram_if.sv
// Data-side bus between the MEM stage (master) and the data RAM (slave).
interface data_ram_if;
   import data_ram_pkg::*;

   logic                ce_i;
   logic                we_i;
   logic [RegBus-1:0]   addr_i;
   logic [NumLanes-1:0] sel_i;
   logic [RegBus-1:0]   data_i;
   logic [RegBus-1:0]   data_o;

   modport master (output ce_i, we_i, addr_i, sel_i, data_i, input data_o);
   modport slave  (input ce_i, we_i, addr_i, sel_i, data_i, output data_o);

endinterface

// File: rtl/data_ram_lane.sv
// One byte lane of the data RAM: clocked write, combinational read.
module data_ram_lane
   import data_ram_pkg::*;
#(
   parameter int unsigned ADDR_W = DataMemNumLog2
) (
   input  logic                 clk,
   input  logic                 i_we,
   input  logic [ADDR_W-1:0]    i_addr,
   input  logic [ByteWidth-1:0] i_din,
   output logic [ByteWidth-1:0] o_dout
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [ByteWidth-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_addr] <= i_din;
   end

   assign o_dout = r_mem[i_addr];

endmodule

// File: rtl/data_ram.sv
// Word-organised big-endian data RAM with post-reset clear sweep and sticky range error.
// Optional access counters are built when DATA_RAM_STATS_EN is defined.
module data_ram
   import data_ram_pkg::*;
#(
   parameter int unsigned ADDR_W = DataMemNumLog2
) (
   input  logic              clk,
   input  logic              rst,
   data_ram_if.slave         bus,
   output logic              stallreq_o,
   output logic              init_done_o,
   output logic              err_o,
   output logic [RegBus-1:0] rd_cnt_o,
   output logic [RegBus-1:0] wr_cnt_o
);

   localparam logic [ADDR_W-1:0] LastIdx = '1;

   dram_state_e       r_state;
   logic [ADDR_W-1:0] r_clr_idx;
   logic              r_stallreq;
   logic              r_init_done;
   logic              r_err;

   logic [ADDR_W-1:0]    w_index;
   logic                 w_in_range;
   logic                 w_run;
   logic                 w_access;
   logic                 w_wr_ok;
   logic                 w_rd_ok;
   logic                 w_oor;
   logic [ADDR_W-1:0]    w_lane_addr;
   logic [NumLanes-1:0]  w_lane_we;
   logic [ByteWidth-1:0] w_lane_din  [NumLanes];
   logic [ByteWidth-1:0] w_lane_dout [NumLanes];
   logic [RegBus-1:0]    w_rd_word;
   logic                 w_unused_addr;

   assign w_index       = bus.addr_i[ADDR_W+1:2];
   assign w_in_range    = (bus.addr_i[RegBus-1:ADDR_W+2] == '0);
   assign w_unused_addr = ^bus.addr_i[1:0];

   assign w_run    = (r_state == DRAM_RUN);
   assign w_access = w_run && (bus.ce_i == ChipEnable);
   assign w_wr_ok  = w_access && (bus.we_i == WriteEnable) && w_in_range;
   assign w_rd_ok  = w_access && (bus.we_i != WriteEnable) && w_in_range;
   assign w_oor    = w_access && !w_in_range;

   // The sweep owns the lane address/data until RUN; bus writes are ignored meanwhile.
   assign w_lane_addr = w_run ? w_index : r_clr_idx;

   for (genvar k = 0; k < NumLanes; k++) begin : g_lane
      assign w_lane_we[k]  = !w_run || (w_wr_ok && bus.sel_i[k]);
      assign w_lane_din[k] = w_run ? lane_byte(bus.data_i, k) : '0;

      data_ram_lane #(
         .ADDR_W (ADDR_W)
      ) u_lane (
         .clk    (clk),
         .i_we   (w_lane_we[k]),
         .i_addr (w_lane_addr),
         .i_din  (w_lane_din[k]),
         .o_dout (w_lane_dout[k])
      );
   end

   always_comb begin
      w_rd_word = '0;
      if (w_rd_ok) begin
         for (int unsigned k = 0; k < NumLanes; k++) begin
            w_rd_word[k*ByteWidth +: ByteWidth] = w_lane_dout[k];
         end
      end
   end

   assign bus.data_o = w_rd_word;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= DRAM_INIT;
         r_clr_idx   <= '0;
         r_stallreq  <= 1'b1;
         r_init_done <= 1'b0;
      end else begin
         case (r_state)
            DRAM_INIT: begin
               r_clr_idx <= r_clr_idx + 1'b1;
               if (r_clr_idx == LastIdx) begin
                  r_state     <= DRAM_RUN;
                  r_stallreq  <= 1'b0;
                  r_init_done <= 1'b1;
               end
            end
            DRAM_RUN: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)        r_err <= 1'b0;
      else if (w_oor) r_err <= 1'b1;
   end

   assign stallreq_o  = r_stallreq;
   assign init_done_o = r_init_done;
   assign err_o       = r_err;

`ifdef DATA_RAM_STATS_EN
   logic [RegBus-1:0] r_rd_cnt;
   logic [RegBus-1:0] r_wr_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_cnt <= '0;
         r_wr_cnt <= '0;
      end else begin
         if (w_rd_ok) r_rd_cnt <= r_rd_cnt + 1'b1;
         if (w_wr_ok) r_wr_cnt <= r_wr_cnt + 1'b1;
      end
   end

   assign rd_cnt_o = r_rd_cnt;
   assign wr_cnt_o = r_wr_cnt;
`else
   assign rd_cnt_o = '0;
   assign wr_cnt_o = '0;
`endif

endmodule

// File: tb/tb_data_ram.sv
// Scoreboard bench for data_ram: directed scenarios plus random traffic against an array model.
module tb_data_ram;

   localparam int unsigned AW    = 4;
   localparam int unsigned DEPTH = 1 << AW;
`ifdef DATA_RAM_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] err;
      logic [31:0] rd;
      logic [31:0] wr;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stallreq, init_done, err;
   logic [31:0] rd_cnt, wr_cnt;

   data_ram_if bus ();

   data_ram #(
      .ADDR_W (AW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .stallreq_o  (stallreq),
      .init_done_o (init_done),
      .err_o       (err),
      .rd_cnt_o    (rd_cnt),
      .wr_cnt_o    (wr_cnt)
   );

   always #5 clk = ~clk;

   logic [31:0] m_mem [DEPTH];
   logic        m_err;
   logic [31:0] m_rd, m_wr;
   exp_t        sb_q [$];
   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   function automatic bit in_range(input logic [31:0] a);
      return (a / (4 * DEPTH)) == 0;
   endfunction

   function automatic int unsigned idx(input logic [31:0] a);
      return int'((a / 4) % DEPTH);
   endfunction

   function automatic logic [31:0] exp_cnt(input logic [31:0] c);
      return STATS ? c : 32'h0;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
      m_err = 1'b0;
      m_rd  = 32'h0;
      m_wr  = 32'h0;
   endtask

   task automatic idle_bus();
      bus.ce_i   = 1'b0;
      bus.we_i   = 1'b0;
      bus.addr_i = 32'h0;
      bus.sel_i  = 4'h0;
      bus.data_i = 32'h0;
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [3:0] sel, input logic [31:0] data);
      bus.ce_i   = 1'b1;
      bus.we_i   = 1'b1;
      bus.addr_i = addr;
      bus.sel_i  = sel;
      bus.data_i = data;
      @(negedge clk);
      check("data_o during write", bus.data_o, 32'h0);
      @(posedge clk);
      if (in_range(addr)) begin
         for (int k = 0; k < 4; k++)
            if (sel[k]) m_mem[idx(addr)][8*k +: 8] = data[8*k +: 8];
         m_wr++;
      end else begin
         m_err = 1'b1;
      end
      #1 idle_bus();
   endtask

   task automatic do_read(input logic [31:0] addr);
      exp_t e;
      e.addr = addr;
      e.data = in_range(addr) ? m_mem[idx(addr)] : 32'h0;
      e.err  = {31'h0, m_err};
      e.rd   = exp_cnt(m_rd);
      e.wr   = exp_cnt(m_wr);
      sb_q.push_back(e);
      bus.ce_i   = 1'b1;
      bus.we_i   = 1'b0;
      bus.addr_i = addr;
      bus.sel_i  = 4'($urandom);
      bus.data_i = $urandom;
      @(posedge clk);
      if (in_range(addr)) m_rd++;
      else m_err = 1'b1;
      #1 idle_bus();
   endtask

   // Counts stall cycles after rst release; optionally fires a write mid-sweep.
   task automatic sweep(input bit inject);
      int unsigned n    = 0;
      bit          done = 1'b0;
      for (int c = 0; c < 4 * DEPTH && !done; c++) begin
         @(negedge clk);
         if (stallreq) begin
            n++;
            if (inject && n == 3) begin
               bus.ce_i   = 1'b1;
               bus.we_i   = 1'b1;
               bus.addr_i = 32'h4;
               bus.sel_i  = 4'hF;
               bus.data_i = 32'hFFFF_FFFF;
            end else if (inject && n == 4) begin
               idle_bus();
            end
         end else begin
            done = 1'b1;
         end
      end
      check("sweep stall cycles", n, DEPTH);
      check("init_done after sweep", {31'h0, init_done}, 32'h1);
      check("err after sweep", {31'h0, err}, 32'h0);
      @(posedge clk);
      #1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && bus.ce_i && !bus.we_i) begin
            if (sb_q.size() == 0) begin
               check("scoreboard underflow", 32'h1, 32'h0);
            end else begin
               e = sb_q.pop_front();
               check($sformatf("read %h data", e.addr), bus.data_o, e.data);
               check($sformatf("read %h err", e.addr), {31'h0, err}, e.err);
               check($sformatf("read %h rd_cnt", e.addr), rd_cnt, e.rd);
               check($sformatf("read %h wr_cnt", e.addr), wr_cnt, e.wr);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [31:0] a;
      idle_bus();
      model_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset stallreq", {31'h0, stallreq}, 32'h1);
      check("reset init_done", {31'h0, init_done}, 32'h0);
      check("reset err", {31'h0, err}, 32'h0);
      check("reset data_o", bus.data_o, 32'h0);
      check("reset rd_cnt", rd_cnt, 32'h0);
      check("reset wr_cnt", wr_cnt, 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      sweep(1'b1);

      for (int i = 0; i < DEPTH; i++) do_read(32'(i * 4));

      do_write(32'h10, 4'hF, 32'hDEAD_BEEF);
      do_read(32'h10);

      do_write(32'h20, 4'hF, 32'h1122_3344);
      do_write(32'h20, 4'b0100, 32'h00AA_0000);
      do_read(32'h20);
      do_write(32'h20, 4'b0000, 32'h5555_5555);
      do_read(32'h20);

      a = 32'(4 * DEPTH);
      do_write(a, 4'hF, 32'h1234_5678);
      do_read(a);
      do_read(32'h0);
      do_write(32'h8000_0000, 4'hF, 32'hFFFF_FFFF);
      do_read(32'h0);

      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 9) == 0)
            a = $urandom | (32'h1 << $urandom_range(AW + 2, 31));
         else
            a = $urandom_range(0, 4 * DEPTH - 1);
         if ($urandom_range(0, 1) == 1) do_write(a, 4'($urandom), $urandom);
         else do_read(a);
      end

      do_write(32'h8, 4'hF, 32'hCAFE_BABE);
      do_read(32'h8);
      rst = 1'b1;
      #1;
      check("async rst stallreq", {31'h0, stallreq}, 32'h1);
      check("async rst init_done", {31'h0, init_done}, 32'h0);
      check("async rst err", {31'h0, err}, 32'h0);
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      sweep(1'b0);
      do_read(32'h8);
      do_read(32'h10);

      repeat (2) @(posedge clk);
      check("scoreboard drained", 32'(sb_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
